// File: rtl/d8m_raw_capture_st.sv
// d8m_raw_capture_st: D8M parallel camera bus to Avalon-ST video packets.
// Define CAPTURE_CTRL_PKT_EN to emit VIP control packets ahead of video.
module d8m_raw_capture_st #(
  parameter int DW         = 12,
  parameter int FIFO_DEPTH = 64,
  parameter int DEF_WIDTH  = 640,
  parameter int DEF_HEIGHT = 480
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic [DW-1:0] cam_d,
  input  logic          cam_fval,
  input  logic          cam_lval,
  input  logic          capture_en,
  output logic [DW-1:0] st_data,
  output logic          st_valid,
  input  logic          st_ready,
  output logic          st_sop,
  output logic          st_eop,
  output logic [15:0]   frame_count,
  output logic [15:0]   last_width,
  output logic [15:0]   last_height,
  output logic          overflow_sticky,
  input  logic          overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = DW + 2;
  localparam logic [AW:0] CAP = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
`ifdef CAPTURE_CTRL_PKT_EN
    ,
    CTRL  = 2'd3
`endif
  } state_t;

  state_t state, state_n;

  logic [DW-1:0] d_q;
  logic          fval_q, lval_q;
  logic          fval_prev, lval_prev;
  logic          rise, fall, pix, lfall;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      d_q       <= '0;
      fval_q    <= 1'b1;
      lval_q    <= 1'b0;
      fval_prev <= 1'b1;
      lval_prev <= 1'b0;
    end else begin
      d_q       <= cam_d;
      fval_q    <= cam_fval;
      lval_q    <= cam_lval;
      fval_prev <= fval_q;
      lval_prev <= lval_q;
    end
  end

  assign rise  = fval_q & ~fval_prev;
  assign fall  = ~fval_q & fval_prev;
  assign pix   = fval_q & lval_q;
  assign lfall = ~lval_q & lval_prev & (fval_q | fval_prev);

  // FIFO holds DEPTH-1 words so full/empty never alias
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, free;
  logic          wr_en, pop;
  logic [FW-1:0] wr_word, rd_word;

  assign free    = CAP - count;
  assign rd_word = mem[rptr];
  assign st_valid = (count != '0);
  assign pop      = st_valid & st_ready;
  assign st_data  = st_valid ? rd_word[DW-1:0] : '0;
  assign st_eop   = st_valid & rd_word[DW];
  assign st_sop   = st_valid & rd_word[DW+1];

  always_ff @(posedge clk_clk) begin
    if (wr_en) mem[wptr] <= wr_word;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
    end
  end

  logic [15:0] width_cnt, line_cnt;
  logic [15:0] w_base, l_base, width_nxt, line_nxt;
  logic        first_done, fd_base;

  always_comb begin
    w_base    = rise ? 16'd0 : width_cnt;
    l_base    = rise ? 16'd0 : line_cnt;
    fd_base   = rise ? 1'b0 : first_done;
    width_nxt = w_base;
    line_nxt  = l_base;
    if (pix && !fd_base && w_base != 16'hFFFF)
      width_nxt = w_base + 16'd1;
    if (lfall && l_base != 16'hFFFF)
      line_nxt = l_base + 16'd1;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      width_cnt  <= '0;
      line_cnt   <= '0;
      first_done <= 1'b0;
    end else begin
      width_cnt  <= width_nxt;
      line_cnt   <= line_nxt;
      first_done <= fd_base | lfall;
    end
  end

  logic [DW-1:0] hold_d;
  logic          hold_v, hold_load, hold_clr;
  logic          ovf_set, done;

`ifdef CAPTURE_CTRL_PKT_EN
  logic [3:0]  cidx;
  logic        ctrl_pend, cidx_inc, ctrl_end;
  logic [15:0] cw, ch;
  logic [3:0]  nib;
  logic        c_sop, c_eop;

  always_comb begin
    nib   = 4'h0;
    c_sop = 1'b0;
    c_eop = 1'b0;
    unique case (cidx)
      4'd0: begin nib = 4'hF; c_sop = 1'b1; end
      4'd1: nib = cw[15:12];
      4'd2: nib = cw[11:8];
      4'd3: nib = cw[7:4];
      4'd4: nib = cw[3:0];
      4'd5: nib = ch[15:12];
      4'd6: nib = ch[11:8];
      4'd7: nib = ch[7:4];
      4'd8: nib = ch[3:0];
      4'd9: begin nib = 4'h3; c_eop = 1'b1; end
      default: nib = 4'h0;
    endcase
  end
`endif

  always_comb begin
    state_n   = state;
    wr_en     = 1'b0;
    wr_word   = '0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    ovf_set   = 1'b0;
    done      = 1'b0;
`ifdef CAPTURE_CTRL_PKT_EN
    cidx_inc  = 1'b0;
    ctrl_end  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
`ifdef CAPTURE_CTRL_PKT_EN
        if (ctrl_pend) begin
          state_n = CTRL;
          ovf_set = rise;
        end else
`endif
        if (rise && capture_en) begin
          if (free >= (AW+1)'(2)) begin
            wr_en     = 1'b1;
            wr_word   = {1'b1, 1'b0, {DW{1'b0}}};
            hold_load = pix;
            state_n   = FRAME;
          end else begin
            ovf_set = 1'b1;
            state_n = DROP;
          end
        end
      end
      FRAME: begin
        if (fall) begin
          wr_en    = 1'b1;
          hold_clr = 1'b1;
          state_n  = IDLE;
          if (hold_v) begin
            wr_word = {1'b0, 1'b1, hold_d};
            done    = 1'b1;
`ifdef CAPTURE_CTRL_PKT_EN
            state_n = CTRL;
`endif
          end else begin
            // header already sent; close it with a dummy pixel
            wr_word = {1'b0, 1'b1, {DW{1'b0}}};
          end
        end else if (pix) begin
          if (hold_v && free == (AW+1)'(1)) begin
            wr_en    = 1'b1;
            wr_word  = {1'b0, 1'b1, hold_d};
            hold_clr = 1'b1;
            ovf_set  = 1'b1;
            state_n  = DROP;
          end else begin
            wr_en     = hold_v;
            wr_word   = {1'b0, 1'b0, hold_d};
            hold_load = 1'b1;
          end
        end
      end
      DROP: begin
        if (!fval_q) state_n = IDLE;
      end
`ifdef CAPTURE_CTRL_PKT_EN
      CTRL: begin
        ovf_set = rise;
        if (cidx != 4'd0 || free >= (AW+1)'(10)) begin
          wr_en    = 1'b1;
          wr_word  = {c_sop, c_eop, {(DW-4){1'b0}}, nib};
          cidx_inc = 1'b1;
          if (cidx == 4'd9) begin
            ctrl_end = 1'b1;
            state_n  = IDLE;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state           <= IDLE;
      hold_d          <= '0;
      hold_v          <= 1'b0;
      frame_count     <= '0;
      last_width      <= '0;
      last_height     <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      state <= state_n;
      if (hold_load) begin
        hold_d <= d_q;
        hold_v <= 1'b1;
      end else if (hold_clr) begin
        hold_v <= 1'b0;
      end
      if (done) begin
        frame_count <= frame_count + 16'd1;
        last_width  <= width_nxt;
        last_height <= line_nxt;
      end
      if (ovf_set)
        overflow_sticky <= 1'b1;
      else if (overflow_clr)
        overflow_sticky <= 1'b0;
    end
  end

`ifdef CAPTURE_CTRL_PKT_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cidx      <= '0;
      ctrl_pend <= 1'b1;
      cw        <= 16'(DEF_WIDTH);
      ch        <= 16'(DEF_HEIGHT);
    end else begin
      if (ctrl_end) begin
        cidx      <= '0;
        ctrl_pend <= 1'b0;
      end else if (cidx_inc) begin
        cidx <= cidx + 4'd1;
      end
      if (done) begin
        cw <= width_nxt;
        ch <= line_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_d8m_raw_capture_st.sv
// tb_d8m_raw_capture_st: directed bench for d8m_raw_capture_st.
// Beats are logged as {sop,eop,data} and compared against hand-built lists.
module tb_d8m_raw_capture_st;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic [DW-1:0] cam_d = '0;
  logic          cam_fval = 1'b0;
  logic          cam_lval = 1'b0;
  logic          capture_en = 1'b1;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready = 1'b1;
  logic          st_sop, st_eop;
  logic [15:0]   frame_count, last_width, last_height;
  logic          overflow_sticky;
  logic          overflow_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int got[$];
  int exp[$];
  bit rnd = 1'b0;

  d8m_raw_capture_st #(.DW(DW), .FIFO_DEPTH(64)) dut (
    .clk_clk        (clk),
    .reset_reset    (reset_reset),
    .cam_d          (cam_d),
    .cam_fval       (cam_fval),
    .cam_lval       (cam_lval),
    .capture_en     (capture_en),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_sop         (st_sop),
    .st_eop         (st_eop),
    .frame_count    (frame_count),
    .last_width     (last_width),
    .last_height    (last_height),
    .overflow_sticky(overflow_sticky),
    .overflow_clr   (overflow_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset_reset && st_valid && st_ready)
      got.push_back(int'({st_sop, st_eop, st_data}));

  always @(posedge clk)
    if (rnd) begin
      #1;
      st_ready = 1'($urandom_range(0, 1));
    end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic cyc(input logic f, input logic lv, input int d);
    @(posedge clk);
    #1;
    cam_fval = f;
    cam_lval = lv;
    cam_d    = DW'(d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_reset = 1'b1;
    cam_fval = 1'b0;
    cam_lval = 1'b0;
    repeat (3) @(posedge clk);
    got.delete();
    exp.delete();
    #1;
    reset_reset = 1'b0;
  endtask

  task automatic frame(input int w, input int h, input int base,
                       input int en_line);
    capture_en = (en_line == 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int l = 0; l < h; l++) begin
      if (l == en_line) capture_en = 1'b1;
      for (int x = 0; x < w; x++) cyc(1, 1, base + l * w + x);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
    end
    repeat (4) cyc(0, 0, 0);
  endtask

  task automatic exp_frame(input int w, input int h, input int base);
    exp.push_back('h2000);
    for (int i = 0; i < w * h - 1; i++) exp.push_back(base + i);
    exp.push_back('h1000 | (base + w * h - 1));
  endtask

  task automatic exp_ctrl(input int w, input int h);
`ifdef CAPTURE_CTRL_PKT_EN
    exp.push_back('h200F);
    for (int s = 12; s >= 0; s -= 4) exp.push_back((w >> s) & 'hF);
    for (int s = 12; s >= 0; s -= 4) exp.push_back((h >> s) & 'hF);
    exp.push_back('h1003);
`else
    if (w < 0 || h < 0) exp.push_back(0);
`endif
  endtask

  task automatic drain();
    int i;
    i = 0;
    repeat (16) @(posedge clk);
    while (st_valid && i < 4000) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("drain_done", 32'(st_valid), 0);
  endtask

  task automatic check_q(input string tag);
    int n;
    check({tag, "_len"}, got.size(), exp.size());
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
    got.delete();
    exp.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_reset = 1'b0;
    #2;
    check("rst_valid", 32'(st_valid), 0);
    check("rst_sop", 32'(st_sop), 0);
    check("rst_eop", 32'(st_eop), 0);
    check("rst_data", 32'(st_data), 0);
    check("rst_fc", 32'(frame_count), 0);
    check("rst_w", 32'(last_width), 0);
    check("rst_h", 32'(last_height), 0);
    check("rst_ovf", 32'(overflow_sticky), 0);

    exp_ctrl(640, 480);
    repeat (4) cyc(0, 0, 0);
    frame(4, 3, 1, 0);
    drain();
    exp_frame(4, 3, 1);
    exp_ctrl(4, 3);
    check_q("f4x3");
    check("f4x3_fc", 32'(frame_count), 1);
    check("f4x3_w", 32'(last_width), 4);
    check("f4x3_h", 32'(last_height), 3);

    cyc(1, 0, 0);
    cyc(1, 1, 7);
    cyc(1, 1, 8);
    cyc(1, 1, 9);
    reset_reset = 1'b1;
    cyc(1, 1, 10);
    cyc(1, 1, 11);
    got.delete();
    reset_reset = 1'b0;
    cyc(1, 1, 12);
    cyc(1, 1, 13);
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    drain();
    exp_ctrl(640, 480);
    check_q("midrst");
    frame(4, 3, 'h20, 0);
    drain();
    exp_frame(4, 3, 'h20);
    exp_ctrl(4, 3);
    check_q("postrst");
    check("postrst_fc", 32'(frame_count), 1);

    st_ready = 1'b0;
    frame(16, 8, 1, 0);
    #1;
    check("trunc_ovf", 32'(overflow_sticky), 1);
    check("trunc_fc", 32'(frame_count), 1);
    check("trunc_valid", 32'(st_valid), 1);
    st_ready = 1'b1;
    drain();
    exp.push_back('h2000);
    for (int i = 1; i < 62; i++) exp.push_back(i);
    exp.push_back('h1000 | 62);
    check_q("trunc");
    @(posedge clk);
    #1;
    overflow_clr = 1'b1;
    @(posedge clk);
    #1;
    overflow_clr = 1'b0;
    check("ovf_clr", 32'(overflow_sticky), 0);

    frame(4, 3, 'h40, 1);
    drain();
    check_q("en_off");
    check("en_off_fc", 32'(frame_count), 1);
    check("en_off_ovf", 32'(overflow_sticky), 0);
    frame(4, 3, 'h50, 0);
    drain();
    exp_frame(4, 3, 'h50);
    exp_ctrl(4, 3);
    check_q("en_on");
    check("en_on_fc", 32'(frame_count), 2);

    do_reset();
    exp_ctrl(640, 480);
    rnd = 1'b1;
    repeat (16) cyc(0, 0, 0);
    for (int f = 1; f <= 3; f++) begin
      frame(8, 4, f * 'h100, 0);
      exp_frame(8, 4, f * 'h100);
      exp_ctrl(8, 4);
      repeat (20) cyc(0, 0, 0);
    end
    rnd = 1'b0;
    @(posedge clk);
    #2;
    st_ready = 1'b1;
    drain();
    check_q("rnd");
    check("rnd_fc", 32'(frame_count), 3);
    check("rnd_w", 32'(last_width), 8);
    check("rnd_h", 32'(last_height), 4);
    check("rnd_ovf", 32'(overflow_sticky), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
